shift_scheduler: RTL and testbench

Round-robin scheduler that shares one `shifter` instance (parallel-load, LSB-first serializer) among `requesters` clients. It arbitrates pending requests, loads the winner's word into the shifter, and streams `depth` beats of `width` bits out through a valid/ready port. It signals per-requester completion and sits between the arbiter request fabric and the serial output link.

---
 rtl/shift_scheduler.sv | 141 ++++++++++++++
 tb/tb_shift_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin owner selection for one shared parallel-load,
// LSB-first serializer. The winner's word is loaded in a single LOAD cycle,
// then streamed out beat by beat over a valid/ready port. A one-cycle done
// pulse marks the acceptance of the owner's last beat.
module shift_scheduler #(
    parameter int requesters = 4,
    parameter int depth      = 4,
    parameter int width      = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [requesters-1:0]              request,
    input  logic [requesters*depth*width-1:0]  word_in,
    output logic [requesters-1:0]              grant,
    output logic [requesters-1:0]              done,
    output logic                               busy,
    output logic                               shift_enable,
    output logic                               shift_load,
    output logic [depth*width-1:0]             shift_parallel_in,
    input  logic [width-1:0]                   shift_serial_out,
    output logic [width-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last
);

    localparam int IDX_W  = (requesters > 1) ? $clog2(requesters) : 1;
    localparam int CNT_W  = (depth > 1) ? $clog2(depth) : 1;
    localparam int WORD_W = depth * width;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_e;

    state_e                 state_q, state_d;
    logic [requesters-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;   // index of the previous winner
    logic [CNT_W-1:0]       count_q, count_d; // beat index within the word

    logic                   req_found;
    logic [IDX_W-1:0]       winner;
    logic [WORD_W-1:0]      words [requesters];

    // Split the flat client bus into one word per client.
    for (genvar k = 0; k < requesters; k++) begin : g_words
        assign words[k] = word_in[k*WORD_W +: WORD_W];
    end

    // Round-robin search: the client right after the previous winner has
    // highest priority, the previous winner itself has lowest.
    always_comb begin
        logic [IDX_W-1:0] cand;
        req_found = 1'b0;
        winner    = last_q;
        cand      = '0;
        for (int i = 1; i <= requesters; i++) begin
            cand = IDX_W'((int'(last_q) + i) % requesters);
            if (!req_found && request[cand]) begin
                req_found = 1'b1;
                winner    = cand;
            end
        end
    end

    // Next-state and output decode for the IDLE/LOAD/SHIFT sequence.
    always_comb begin
        // NOTE: every output and next-state signal gets a default before the
        // case statement, so no path through the block can infer a latch.
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        count_d           = count_q;
        busy              = 1'b0;
        shift_enable      = 1'b0;
        shift_load        = 1'b0;
        shift_parallel_in = '0;
        out_valid         = 1'b0;
        out_last          = 1'b0;
        done              = '0;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = {{(requesters-1){1'b0}}, 1'b1} << winner;
                    last_d  = winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // last_q already holds the owner; its word is sampled here only.
                busy              = 1'b1;
                shift_enable      = 1'b1;
                shift_load        = 1'b1;
                shift_parallel_in = words[last_q];
                count_d           = '0;
                state_d           = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (count_q == CNT_W'(depth - 1));
                // Without out_ready everything holds and the shifter stays put.
                if (out_ready) begin
                    shift_enable = 1'b1;
                    if (out_last) begin
                        done    = grant_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves the pointer on the last client so that
    // client 0 wins the first arbitration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(requesters - 1);
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from values sampled at the same edge.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign grant    = grant_q;
    assign out_data = shift_serial_out;

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: a 4-client/4-beat instance driven through a
// vector table and hand-written sequences with a beat scoreboard, plus a
// 2-client/1-beat instance for the single-beat corner case. Both instances
// talk to small behavioural shifters kept in this file.
module tb_shift_scheduler;

    localparam int RQ = 4;
    localparam int DP = 4;
    localparam int WD = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- main instance (4 clients, depth 4) ----------------
    logic [RQ-1:0]       request;
    logic [RQ*DP*WD-1:0] word_in;
    logic [RQ-1:0]       grant, done;
    logic                busy, shift_enable, shift_load;
    logic [DP*WD-1:0]    shift_parallel_in;
    logic [WD-1:0]       shift_serial_out, out_data;
    logic                out_valid, out_ready, out_last;

    logic [31:0] w [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h0FEEDDCC};

    shift_scheduler #(.requesters(RQ), .depth(DP), .width(WD)) dut (
        .clock(clock), .reset_n(reset_n), .request(request), .word_in(word_in),
        .grant(grant), .done(done), .busy(busy), .shift_enable(shift_enable),
        .shift_load(shift_load), .shift_parallel_in(shift_parallel_in),
        .shift_serial_out(shift_serial_out), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    logic [31:0] sh_a = 32'h0;
    always @(posedge clock) if (shift_enable) sh_a <= shift_load ? shift_parallel_in : (sh_a >> 8);
    assign shift_serial_out = sh_a[7:0];

    // ---------------- single-beat instance (2 clients, depth 1) ----------------
    logic [1:0]  request_b, grant_b, done_b;
    logic [15:0] word_b;
    logic        busy_b, shift_enable_b, shift_load_b, out_valid_b, out_ready_b, out_last_b;
    logic [7:0]  shift_parallel_in_b, shift_serial_out_b, out_data_b;

    shift_scheduler #(.requesters(2), .depth(1), .width(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .request(request_b), .word_in(word_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .shift_enable(shift_enable_b),
        .shift_load(shift_load_b), .shift_parallel_in(shift_parallel_in_b),
        .shift_serial_out(shift_serial_out_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b)
    );

    logic [7:0] sh_b = 8'h0;
    always @(posedge clock) if (shift_enable_b && shift_load_b) sh_b <= shift_parallel_in_b;
    assign shift_serial_out_b = sh_b;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        int          cyc;
        logic [3:0]  grant;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  done;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_e;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  grant;
        logic        busy, en, load, valid;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  done;
        logic [31:0] pin;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue the four beats of one transfer whose LOAD cycle is load_cyc;
    // beats from stall_beat onward are delayed by stall_n cycles.
    task automatic push_transfer(input int load_cyc, input int client,
                                 input int stall_beat, input int stall_n);
        for (int b = 0; b < DP; b++) begin
            beat_t e;
            e.cyc   = load_cyc + 1 + b + ((b >= stall_beat) ? stall_n : 0);
            e.grant = 4'(1 << client);
            e.data  = w[client][8*b +: 8];
            e.last  = (b == DP - 1);
            e.done  = (b == DP - 1) ? 4'(1 << client) : 4'b0000;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        tick();
        @(negedge clock);
        check("idle_after", 64'({grant, busy, out_valid}), 64'd0);
        tick();
    endtask

    // Every accepted beat must match the next expected beat, including the
    // cycle it arrives in; done may only appear on an accepted beat.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_beat: got data 0x%0h grant 0x%0h with nothing expected (cycle %0d)",
                         out_data, grant, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_beat", 64'({cyc, grant, out_data, out_last, done}), 64'(mon_e));
            end
        end else if (reset_n && done != 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL done_without_beat: got done 0x%0h, expected 0x0 (cycle %0d)", done, cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        reset_n     = 1'b0;
        request     = '0;
        out_ready   = 1'b1;
        word_in     = {w[3], w[2], w[1], w[0]};
        request_b   = '0;
        out_ready_b = 1'b1;
        word_b      = {8'hBB, 8'hAA};

        // ---- reset state ----
        #3;
        check("reset_outputs", 64'({grant, done, busy, shift_enable, shift_load,
                                    shift_parallel_in, out_valid, out_last}), 64'd0);
        check("reset_out_data", 64'(out_data), 64'(shift_serial_out));
        check("reset_outputs_b", 64'({grant_b, done_b, busy_b, shift_enable_b, shift_load_b,
                                      shift_parallel_in_b, out_valid_b, out_last_b}), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // ---- fairness: all four request, order 0,1,2,3,0,1, 6 cycles each ----
        n = cyc;
        request = 4'b1111;
        for (int k = 0; k < 6; k++) push_transfer(n + 1 + 6*k, k % 4, 99, 0);
        while (cyc < n + 33) tick();
        request = 4'b0000;
        drain(60);

        // ---- single client, table driven ----
        vecs[0] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 32'h0};
        vecs[1] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 32'h44332211};
        vecs[2] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 4'b0000, 32'h0};
        vecs[3] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 4'b0000, 32'h0};
        vecs[4] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 4'b0000, 32'h0};
        vecs[5] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 4'b0001, 32'h0};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 32'h0};
        vecs[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 32'h0};
        n = cyc;
        push_transfer(n + 1, 0, 99, 0);
        for (int i = 0; i < 8; i++) begin
            request   = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(negedge clock);
            check($sformatf("vec%0d", i),
                  64'({grant, busy, shift_enable, shift_load, out_valid,
                       (out_valid ? out_data : 8'h00), out_last, done, shift_parallel_in}),
                  64'({vecs[i].grant, vecs[i].busy, vecs[i].en, vecs[i].load, vecs[i].valid,
                       vecs[i].data, vecs[i].last, vecs[i].done, vecs[i].pin}));
            tick();
        end
        out_ready = 1'b1;
        drain(10);

        // ---- backpressure: 3 stall cycles on the second beat ----
        n = cyc;
        request = 4'b0001;
        push_transfer(n + 1, 0, 1, 3);
        tick();
        request = 4'b0000;
        tick();
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check($sformatf("stall%0d", s), 64'({out_valid, out_data, shift_enable, done}),
                  64'({1'b1, 8'h22, 1'b0, 4'b0000}));
            tick();
        end
        out_ready = 1'b1;
        drain(20);

        // ---- withdrawal: client 2 drops during its LOAD, still completes ----
        n = cyc;
        request = 4'b0100;
        push_transfer(n + 1, 2, 99, 0);
        tick();
        request = 4'b0000;
        drain(20);

        // ---- withdrawal: client 3 requests and drops while client 1 owns ----
        n = cyc;
        request = 4'b0010;
        push_transfer(n + 1, 1, 99, 0);
        tick();
        request = 4'b1010;
        tick();
        tick();
        request = 4'b0000;
        drain(20);
        repeat (6) tick();
        @(negedge clock);
        check("client3_never_granted", 64'({grant, busy}), 64'd0);
        tick();

        // ---- reset mid-transfer, then client 0 regains priority ----
        n = cyc;
        request = 4'b0101;
        begin
            beat_t e;
            e.cyc   = n + 2;
            e.grant = 4'b0100;
            e.data  = w[2][7:0];
            e.last  = 1'b0;
            e.done  = 4'b0000;
            sb_q.push_back(e);
        end
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", 64'({grant, done, busy, shift_enable, shift_load,
                                       shift_parallel_in, out_valid, out_last}), 64'd0);
        check("midreset_queue", 64'(sb_q.size()), 64'd0);
        tick();
        tick();
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        m = cyc;
        push_transfer(m + 1, 0, 99, 0);
        tick();
        request = 4'b0000;
        drain(20);

        // ---- depth 1: two clients alternate, 3 cycles per transfer ----
        n = cyc;
        request_b = 2'b11;
        for (int k = 0; k < 4; k++) begin
            while (cyc < n + 2 + 3*k) tick();
            @(negedge clock);
            check($sformatf("d1_beat%0d", k),
                  64'({grant_b, done_b, out_valid_b, out_last_b, shift_enable_b, out_data_b}),
                  64'({2'(1 << (k % 2)), 2'(1 << (k % 2)), 1'b1, 1'b1, 1'b1,
                       ((k % 2) != 0) ? 8'hBB : 8'hAA}));
            tick();
            if (k == 3) request_b = 2'b00;
            @(negedge clock);
            check($sformatf("d1_gap%0d", k), 64'({grant_b, busy_b, out_valid_b}), 64'd0);
        end
        repeat (3) tick();
        @(negedge clock);
        check("d1_idle", 64'({grant_b, busy_b, out_valid_b}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
